// File: rtl/mem_access_if.sv
// Pipeline-to-RAM bundle for the MEM-stage access controller.
// master = controller side, slave = pipeline/RAM environment side.
interface mem_access_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  mem_read_flag;
    logic                  mem_write_flag;
    logic                  mem_sign_ext_flag;
    logic [3:0]            mem_sel;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_write_data;
    logic                  stall_req;
    logic [31:0]           load_data;
    logic                  addr_error;
    logic                  bus_error;
    logic                  ram_en;
    logic [3:0]            ram_write_en;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]           ram_write_data;
    logic [31:0]           ram_read_data;
    logic                  ram_ready;

    modport master (
        input  mem_read_flag, mem_write_flag, mem_sign_ext_flag, mem_sel,
               mem_addr, mem_write_data, ram_read_data, ram_ready,
        output stall_req, load_data, addr_error, bus_error,
               ram_en, ram_write_en, ram_addr, ram_write_data
    );

    modport slave (
        output mem_read_flag, mem_write_flag, mem_sign_ext_flag, mem_sel,
               mem_addr, mem_write_data, ram_read_data, ram_ready,
        input  stall_req, load_data, addr_error, bus_error,
               ram_en, ram_write_en, ram_addr, ram_write_data
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer: one handshaked RAM access per
// instruction, pipeline stall until acknowledge, aligned/extended load return.
module mem_access_ctrl #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic           i_clk,
    input  logic           i_rst,
    mem_access_if.master   bus
);
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic                  r_ram_en, w_ram_en_nxt;
    logic [3:0]            r_ram_we, w_ram_we_nxt;
    logic [ADDR_WIDTH-1:0] r_ram_addr, w_ram_addr_nxt;
    logic [31:0]           r_ram_wdata, w_ram_wdata_nxt;
    logic [31:0]           r_load_data, w_load_data_nxt;
    logic                  r_addr_err, w_addr_err_nxt;
    logic                  r_bus_err, w_bus_err_nxt;
    logic [1:0]            r_off, w_off_nxt;
    logic [3:0]            r_sel, w_sel_nxt;
    logic                  r_sext, w_sext_nxt;
    logic                  r_is_wr, w_is_wr_nxt;
    logic                  w_stall;

    logic                  w_req;
    logic                  w_aligned;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata_rep;
    logic [31:0]           w_shifted;
    logic [31:0]           w_load_ext;

    assign w_req = (bus.mem_read_flag | bus.mem_write_flag) & (|bus.mem_sel);
    assign w_be  = bus.mem_sel << bus.mem_addr[1:0];

    // Alignment and store-lane replication from the incoming access size
    always_comb begin
        w_aligned   = 1'b0;
        w_wdata_rep = bus.mem_write_data;
        case (bus.mem_sel)
            4'b0001: begin
                w_aligned   = 1'b1;
                w_wdata_rep = {4{bus.mem_write_data[7:0]}};
            end
            4'b0011: begin
                w_aligned   = ~bus.mem_addr[0];
                w_wdata_rep = {2{bus.mem_write_data[15:0]}};
            end
            4'b1111: w_aligned = (bus.mem_addr[1:0] == 2'b00);
            default: w_aligned = 1'b0;
        endcase
    end

    // Load lane extraction uses the offset/size latched at request time
    assign w_shifted = bus.ram_read_data >> {r_off, 3'b000};

    always_comb begin
        case (r_sel)
            4'b0001: w_load_ext = {{24{r_sext & w_shifted[7]}}, w_shifted[7:0]};
            4'b0011: w_load_ext = {{16{r_sext & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_ext = w_shifted;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_ram_en_nxt    = r_ram_en;
        w_ram_we_nxt    = r_ram_we;
        w_ram_addr_nxt  = r_ram_addr;
        w_ram_wdata_nxt = r_ram_wdata;
        w_load_data_nxt = r_load_data;
        w_addr_err_nxt  = r_addr_err;
        w_bus_err_nxt   = r_bus_err;
        w_off_nxt       = r_off;
        w_sel_nxt       = r_sel;
        w_sext_nxt      = r_sext;
        w_is_wr_nxt     = r_is_wr;
        w_stall         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_stall = 1'b1;
                    if (w_aligned) begin
                        w_state_nxt     = S_BUSY;
                        w_ram_en_nxt    = 1'b1;
                        w_ram_addr_nxt  = {bus.mem_addr[ADDR_WIDTH-1:2], 2'b00};
                        w_ram_we_nxt    = bus.mem_write_flag ? w_be : 4'b0000;
                        w_ram_wdata_nxt = w_wdata_rep;
                        w_off_nxt       = bus.mem_addr[1:0];
                        w_sel_nxt       = bus.mem_sel;
                        w_sext_nxt      = bus.mem_sign_ext_flag;
                        w_is_wr_nxt     = bus.mem_write_flag;
                        w_cnt_nxt       = '0;
                    end else begin
                        w_state_nxt     = S_DONE;
                        w_addr_err_nxt  = 1'b1;
                        w_load_data_nxt = '0;
                    end
                end
            end
            S_BUSY: begin
                w_stall = 1'b1;
                if (bus.ram_ready) begin
                    w_state_nxt     = S_DONE;
                    w_ram_en_nxt    = 1'b0;
                    w_ram_we_nxt    = 4'b0000;
                    w_load_data_nxt = r_is_wr ? 32'd0 : w_load_ext;
                    w_cnt_nxt       = '0;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Last permitted wait cycle elapsed without acknowledge
                    w_state_nxt     = S_DONE;
                    w_ram_en_nxt    = 1'b0;
                    w_ram_we_nxt    = 4'b0000;
                    w_bus_err_nxt   = 1'b1;
                    w_load_data_nxt = '0;
                    w_cnt_nxt       = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt     = S_IDLE;
                w_load_data_nxt = '0;
                w_addr_err_nxt  = 1'b0;
                w_bus_err_nxt   = 1'b0;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt       <= '0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 4'b0000;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_load_data <= '0;
            r_addr_err  <= 1'b0;
            r_bus_err   <= 1'b0;
            r_off       <= 2'b00;
            r_sel       <= 4'b0000;
            r_sext      <= 1'b0;
            r_is_wr     <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_ram_en    <= w_ram_en_nxt;
            r_ram_we    <= w_ram_we_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_ram_wdata <= w_ram_wdata_nxt;
            r_load_data <= w_load_data_nxt;
            r_addr_err  <= w_addr_err_nxt;
            r_bus_err   <= w_bus_err_nxt;
            r_off       <= w_off_nxt;
            r_sel       <= w_sel_nxt;
            r_sext      <= w_sext_nxt;
            r_is_wr     <= w_is_wr_nxt;
        end
    end

    assign bus.stall_req      = w_stall;
    assign bus.load_data      = r_load_data;
    assign bus.addr_error     = r_addr_err;
    assign bus.bus_error      = r_bus_err;
    assign bus.ram_en         = r_ram_en;
    assign bus.ram_write_en   = r_ram_we;
    assign bus.ram_addr       = r_ram_addr;
    assign bus.ram_write_data = r_ram_wdata;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench: transaction-level reference model drives per-cycle
// expectations; a negedge compare process checks every cycle.
module tb_mem_access_ctrl;
    localparam int unsigned AW = 32;
    localparam int unsigned T  = 255;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_access_if #(.ADDR_WIDTH(AW)) bus ();

    mem_access_ctrl #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outputs for the current cycle
    logic        e_valid = 1'b0;
    logic        e_stall, e_en, e_aerr, e_berr, e_chk_addr, e_chk_wdata;
    logic [3:0]  e_we;
    logic [31:0] e_addr, e_wdata, e_ld;

    always @(negedge clk) begin
        if (e_valid) begin
            chk("stall_req",  32'(bus.stall_req),    32'(e_stall));
            chk("ram_en",     32'(bus.ram_en),       32'(e_en));
            chk("ram_we",     32'(bus.ram_write_en), 32'(e_we));
            chk("load_data",  bus.load_data,         e_ld);
            chk("addr_error", 32'(bus.addr_error),   32'(e_aerr));
            chk("bus_error",  32'(bus.bus_error),    32'(e_berr));
            if (e_chk_addr)  chk("ram_addr",  bus.ram_addr,       e_addr);
            if (e_chk_wdata) chk("ram_wdata", bus.ram_write_data, e_wdata);
        end
    end

    // Reference model
    function automatic int size_of(input logic [3:0] sel);
        case (sel)
            4'b0001: return 1;
            4'b0011: return 2;
            4'b1111: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] exp_strobe(input logic [3:0] sel, input logic [31:0] addr);
        logic [3:0] s;
        int off;
        off = int'(addr % 4);
        s = 4'b0000;
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + size_of(sel)) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [3:0] sel, input logic [31:0] w);
        case (size_of(sel))
            1:       return {24'd0, w[7:0]} * 32'h0101_0101;
            2:       return {16'd0, w[15:0]} * 32'h0001_0001;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [3:0] sel, input logic [31:0] addr,
                                             input logic sext, input logic [31:0] rd);
        logic [7:0]  b [4];
        logic [31:0] v;
        int off;
        off = int'(addr % 4);
        for (int i = 0; i < 4; i++) b[i] = rd[8*i +: 8];
        case (size_of(sel))
            1: begin
                v = {24'd0, b[off]};
                if (sext && v >= 32'h80) v = v + 32'hFFFF_FF00;
            end
            2: begin
                v = {16'd0, b[off+1], b[off]};
                if (sext && v >= 32'h8000) v = v + 32'hFFFF_0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    // Per-transaction observations for literal checks
    int          c_stall, c_en, c_aerr, c_berr;
    logic [31:0] c_ld, c_addr, c_wdata;
    logic [3:0]  c_we;

    task automatic step(input bit is_done = 1'b0, input bit first_busy = 1'b0);
        @(negedge clk);
        if (bus.stall_req)  c_stall++;
        if (bus.ram_en)     c_en++;
        if (bus.addr_error) c_aerr++;
        if (bus.bus_error)  c_berr++;
        if (is_done) c_ld = bus.load_data;
        if (first_busy) begin
            c_we    = bus.ram_write_en;
            c_addr  = bus.ram_addr;
            c_wdata = bus.ram_write_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic exp_quiet(input logic stall);
        e_stall = stall; e_en = 1'b0; e_we = 4'b0000; e_ld = '0;
        e_aerr = 1'b0; e_berr = 1'b0; e_chk_addr = 1'b0; e_chk_wdata = 1'b0;
    endtask

    task automatic clear_caps();
        c_stall = 0; c_en = 0; c_aerr = 0; c_berr = 0;
        c_ld = '0; c_addr = '0; c_wdata = '0; c_we = '0;
    endtask

    task automatic idle_cycle();
        bus.mem_read_flag = 1'b0; bus.mem_write_flag = 1'b0;
        bus.ram_ready = 1'b0;
        exp_quiet(1'b0);
        step();
    endtask

    task automatic run_txn(input logic rd, input logic wr, input logic sext, input logic [3:0] sel,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int nwait);
        bit req, aligned, timeout;
        int sz, nb;
        clear_caps();
        bus.mem_read_flag = rd; bus.mem_write_flag = wr; bus.mem_sign_ext_flag = sext;
        bus.mem_sel = sel; bus.mem_addr = addr; bus.mem_write_data = wdata;
        bus.ram_ready = 1'b0;
        sz      = size_of(sel);
        req     = (rd || wr) && (sel != 4'b0000);
        aligned = (sz != 0) && (addr % sz == 0);
        if (!req) begin
            exp_quiet(1'b0);
            step();
            return;
        end
        exp_quiet(1'b1);
        step();
        if (!aligned) begin
            exp_quiet(1'b0);
            e_aerr = 1'b1;
            step(1'b1);
            return;
        end
        timeout = (nwait >= int'(T));
        nb      = timeout ? int'(T) : nwait + 1;
        exp_quiet(1'b1);
        e_en = 1'b1;
        e_we = wr ? exp_strobe(sel, addr) : 4'b0000;
        e_addr = addr - (addr % 4); e_chk_addr = 1'b1;
        e_wdata = exp_wdata(sel, wdata); e_chk_wdata = wr;
        for (int k = 0; k < nb; k++) begin
            bus.ram_ready     = !timeout && (k == nwait);
            bus.ram_read_data = bus.ram_ready ? rdata : $urandom;
            step(1'b0, k == 0);
        end
        bus.ram_ready = 1'b0;
        bus.ram_read_data = $urandom;
        exp_quiet(1'b0);
        e_ld   = (!wr && !timeout) ? exp_load(sel, addr, sext, rdata) : 32'd0;
        e_berr = timeout;
        step(1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        logic [3:0] sel;
        int r;
        rst = 1'b1;
        bus.mem_read_flag = 1'b0; bus.mem_write_flag = 1'b0; bus.mem_sign_ext_flag = 1'b0;
        bus.mem_sel = 4'b0000; bus.mem_addr = '0; bus.mem_write_data = '0;
        bus.ram_read_data = '0; bus.ram_ready = 1'b0;
        clear_caps();
        @(posedge clk); #1;
        exp_quiet(1'b0);
        e_valid = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();

        // Word load, ready on first BUSY cycle
        run_txn(1, 0, 0, 4'hF, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
        chk("word_ld_addr",  c_addr, 32'h100);
        chk("word_ld_we",    32'(c_we), 32'h0);
        chk("word_ld_stall", 32'(c_stall), 32'd2);
        chk("word_ld_data",  c_ld, 32'hDEAD_BEEF);

        // Signed / unsigned byte load from the top lane
        run_txn(1, 0, 1, 4'h1, 32'h103, 32'h0, 32'h8012_3456, 0);
        chk("sbyte_ld_data", c_ld, 32'hFFFF_FF80);
        run_txn(1, 0, 0, 4'h1, 32'h103, 32'h0, 32'h8012_3456, 0);
        chk("ubyte_ld_data", c_ld, 32'h0000_0080);

        // Half store to upper half-word
        run_txn(0, 1, 0, 4'h3, 32'h202, 32'h0000_ABCD, 32'h1234_5678, 0);
        chk("half_st_addr",  c_addr, 32'h200);
        chk("half_st_we",    32'(c_we), 32'hC);
        chk("half_st_wdata", c_wdata, 32'hABCD_ABCD);
        chk("half_st_ld",    c_ld, 32'h0);

        // Misaligned word access
        run_txn(1, 0, 0, 4'hF, 32'h101, 32'h0, 32'h0, 0);
        chk("misal_en",    32'(c_en), 32'd0);
        chk("misal_aerr",  32'(c_aerr), 32'd1);
        chk("misal_stall", 32'(c_stall), 32'd1);

        // Three wait states
        run_txn(1, 0, 0, 4'hF, 32'h104, 32'h0, 32'hCAFE_F00D, 3);
        chk("wait3_stall", 32'(c_stall), 32'd5);
        chk("wait3_en",    32'(c_en), 32'd4);
        chk("wait3_data",  c_ld, 32'hCAFE_F00D);

        // Ready never arrives
        run_txn(1, 0, 0, 4'hF, 32'h108, 32'h0, 32'h0, 1000);
        chk("tmo_berr", 32'(c_berr), 32'd1);
        chk("tmo_en",   32'(c_en), 32'd255);
        chk("tmo_ld",   c_ld, 32'h0);
        idle_cycle();

        // Reset during BUSY, then a late ready pulse
        clear_caps();
        bus.mem_read_flag = 1'b1; bus.mem_write_flag = 1'b0; bus.mem_sel = 4'hF;
        bus.mem_addr = 32'h300; bus.ram_ready = 1'b0;
        exp_quiet(1'b1);
        step();
        exp_quiet(1'b1);
        e_en = 1'b1; e_addr = 32'h300; e_chk_addr = 1'b1;
        step(1'b0, 1'b1);
        rst = 1'b1;
        bus.mem_read_flag = 1'b0;
        step();
        rst = 1'b0;
        bus.ram_ready = 1'b1; bus.ram_read_data = 32'h5555_AAAA;
        exp_quiet(1'b0);
        step();
        bus.ram_ready = 1'b0;
        step();
        chk("rst_busy_en", 32'(c_en), 32'd2);
        run_txn(1, 0, 0, 4'h3, 32'h302, 32'h0, 32'h8001_7FFF, 1);
        chk("post_rst_ld", c_ld, 32'h0000_8001);

        // Randomized traffic
        for (int n = 0; n < 120; n++) begin
            r = int'($urandom_range(0, 7));
            case (r)
                0, 1:    sel = 4'h1;
                2, 3:    sel = 4'h3;
                4, 5:    sel = 4'hF;
                6:       sel = 4'h0;
                default: sel = 4'($urandom_range(0, 15));
            endcase
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    sel, $urandom, $urandom, $urandom, int'($urandom_range(0, 4)));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
